// File: rtl/j1a_bus_responder.sv
// j1a_bus_responder: serializes J1A instruction fetch and data access onto one memory.
// Optional store write-protect of instruction space: define J1A_INS_WP_EN.
module j1a_bus_responder #(
    parameter int unsigned MEM_WAIT = 1,
    parameter logic [1:0]  INS_PAGE = 2'b00
) (
    input  logic        sys_clk_i,
    input  logic        sys_res_n_i,
    input  logic [12:0] ins_adr_i,
    input  logic        ins_cyc_i,
    output logic [15:0] ins_dat_o,
    input  logic [14:0] dat_adr_i,
    input  logic [15:0] dat_dat_i,
    output logic [15:0] dat_dat_o,
    input  logic        dat_we_i,
    input  logic        dat_cyc_i,
    input  logic        shr_stb_i,
    output logic        shr_ack_o,
    output logic [14:0] mem_adr_o,
    output logic [15:0] mem_dat_o,
    input  logic [15:0] mem_dat_i,
    output logic        mem_en_o,
    output logic        mem_we_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INS  = 2'd1;
    localparam logic [1:0] S_DAT  = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    logic [1:0]  state;
    logic [3:0]  wcnt;
    logic        req_d;
    logic        abort;
    logic [14:0] dat_adr_q;
    logic        dat_we_q;
    logic        last;
    logic        start;
    logic        wp;

    assign last  = (wcnt == WAIT_LAST);
    assign start = shr_stb_i & (ins_cyc_i | dat_cyc_i);

`ifdef J1A_INS_WP_EN
    assign wp = (dat_adr_q[14:13] == INS_PAGE);
`else
    assign wp = 1'b0;
`endif

    // Memory and bus outputs decoded from the current phase.
    always_comb begin
        mem_en_o  = 1'b0;
        mem_we_o  = 1'b0;
        mem_adr_o = 15'd0;
        shr_ack_o = 1'b0;
        unique case (state)
            S_INS: begin
                mem_en_o  = 1'b1;
                mem_adr_o = {INS_PAGE, ins_adr_i};
            end
            S_DAT: begin
                mem_en_o  = 1'b1;
                mem_we_o  = dat_we_q & ~wp;
                mem_adr_o = dat_adr_q;
            end
            S_ACK: begin
                shr_ack_o = shr_stb_i & ~abort;
            end
            default: begin
                mem_en_o = 1'b0;
            end
        endcase
    end

    // Phase sequencing, wait counting and request latching.
    always_ff @(posedge sys_clk_i or negedge sys_res_n_i) begin
        if (!sys_res_n_i) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            req_d     <= 1'b0;
            abort     <= 1'b0;
            dat_adr_q <= 15'd0;
            dat_we_q  <= 1'b0;
            mem_dat_o <= 16'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    abort <= 1'b0;
                    wcnt  <= 4'd0;
                    if (start) begin
                        req_d     <= dat_cyc_i;
                        dat_adr_q <= dat_adr_i;
                        dat_we_q  <= dat_we_i;
                        mem_dat_o <= dat_dat_i;
                        state     <= ins_cyc_i ? S_INS : S_DAT;
                    end
                end
                S_INS: begin
                    if (!shr_stb_i) abort <= 1'b1;
                    if (last) begin
                        wcnt  <= 4'd0;
                        state <= req_d ? S_DAT : S_ACK;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                S_DAT: begin
                    if (!shr_stb_i) abort <= 1'b1;
                    if (last) begin
                        wcnt  <= 4'd0;
                        state <= S_ACK;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Fetched instruction word, captured on the last cycle of the fetch.
    always_ff @(posedge sys_clk_i or negedge sys_res_n_i) begin
        if (!sys_res_n_i) begin
            ins_dat_o <= 16'd0;
        end else if (state == S_INS && last) begin
            ins_dat_o <= mem_dat_i;
        end
    end

    // Load datum, captured on the last cycle of a data read only.
    always_ff @(posedge sys_clk_i or negedge sys_res_n_i) begin
        if (!sys_res_n_i) begin
            dat_dat_o <= 16'd0;
        end else if (state == S_DAT && last && !dat_we_q) begin
            dat_dat_o <= mem_dat_i;
        end
    end

endmodule

// File: tb/tb_j1a_bus_responder.sv
// tb_j1a_bus_responder: randomized bench with a memory model and a
// transaction-level reference for j1a_bus_responder.
module tb_j1a_bus_responder;

    localparam int unsigned MW       = 1;
    localparam logic [1:0]  INS_PAGE = 2'b00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] ins_adr_i = '0;
    logic        ins_cyc_i = 1'b0;
    logic [15:0] ins_dat_o;
    logic [14:0] dat_adr_i = '0;
    logic [15:0] dat_dat_i = '0;
    logic [15:0] dat_dat_o;
    logic        dat_we_i = 1'b0;
    logic        dat_cyc_i = 1'b0;
    logic        shr_stb_i = 1'b0;
    logic        shr_ack_o;
    logic [14:0] mem_adr_o;
    logic [15:0] mem_dat_o;
    logic [15:0] mem_dat_i;
    logic        mem_en_o;
    logic        mem_we_o;

    int n_tests = 0;
    int n_fail = 0;

    logic [15:0] mem [0:32767];
    logic [15:0] ref_mem [0:32767];
    logic [15:0] ref_ins = 16'd0;
    logic [15:0] ref_dat = 16'd0;
    logic        filled = 1'b0;
    logic        poke = 1'b0;
    logic [14:0] poke_adr = '0;
    logic [15:0] poke_dat = '0;
    int          age = 0;
    logic        en_prev = 1'b0;
    logic [14:0] adr_prev = '0;
    logic        held;

    j1a_bus_responder #(.MEM_WAIT(MW), .INS_PAGE(INS_PAGE)) dut (
        .sys_clk_i(clk), .sys_res_n_i(rst_n),
        .ins_adr_i(ins_adr_i), .ins_cyc_i(ins_cyc_i), .ins_dat_o(ins_dat_o),
        .dat_adr_i(dat_adr_i), .dat_dat_i(dat_dat_i), .dat_dat_o(dat_dat_o),
        .dat_we_i(dat_we_i), .dat_cyc_i(dat_cyc_i),
        .shr_stb_i(shr_stb_i), .shr_ack_o(shr_ack_o),
        .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 40503) ^ 16'h5A3C;
    endfunction

    // Memory model: read data is valid only after the address has been
    // held for MW cycles, otherwise a poison pattern is returned.
    assign held = mem_en_o && en_prev && (mem_adr_o == adr_prev);
    assign mem_dat_i = (mem_en_o && ((held ? age : 0) >= int'(MW)))
                       ? mem[mem_adr_o] : 16'hDEAD;

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 32768; i++) mem[i] <= init_val(i);
            filled <= 1'b1;
        end else if (poke) begin
            mem[poke_adr] <= poke_dat;
        end else if (mem_en_o && mem_we_o) begin
            mem[mem_adr_o] <= mem_dat_o;
        end
        if (mem_en_o) age <= held ? age + 1 : 1;
        else age <= 0;
        en_prev  <= mem_en_o;
        adr_prev <= mem_adr_o;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_mem(input logic [14:0] a, input logic [15:0] d);
        poke = 1'b1; poke_adr = a; poke_dat = d;
        @(negedge clk);
        poke = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic idle_bus();
        shr_stb_i = 1'b0; ins_cyc_i = 1'b0; dat_cyc_i = 1'b0;
    endtask

    // One CPU step. Called and returns at a negedge.
    task automatic txn(input bit ic, input bit dc, input bit we,
                       input logic [12:0] ia, input logic [14:0] da,
                       input logic [15:0] dd, input bit dropit);
        int lat, drop, ack_n, ack_k, en_n, we_n, bad, iend;
        bit wp;
        logic [15:0] e_ins, e_dat;
        logic [14:0] e_adr;
        bit e_en;
        wp = 1'b0;
`ifdef J1A_INS_WP_EN
        wp = dc && we && (da[14:13] == INS_PAGE);
`endif
        e_ins = ic ? ref_mem[{INS_PAGE, ia}] : ref_ins;
        e_dat = (dc && !we) ? ref_mem[da] : ref_dat;
        if (dc && we && !wp) ref_mem[da] = dd;
        lat  = (ic && dc) ? 2 * int'(MW) + 3 : int'(MW) + 2;
        drop = dropit ? int'($urandom_range(1, lat - 1)) : 0;
        iend = ic ? int'(MW) + 1 : 0;
        ack_n = 0; ack_k = 0; en_n = 0; we_n = 0; bad = 0;
        ins_adr_i = ia; ins_cyc_i = ic;
        dat_adr_i = da; dat_dat_i = dd; dat_we_i = we; dat_cyc_i = dc;
        shr_stb_i = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (shr_ack_o) begin ack_n++; ack_k = k; end
            if (mem_en_o) en_n++;
            if (mem_we_o) we_n++;
            e_en = 1'b0; e_adr = '0;
            if (k <= iend) begin
                e_en = 1'b1; e_adr = {INS_PAGE, ia};
            end else if (dc && k <= iend + int'(MW) + 1) begin
                e_en = 1'b1; e_adr = da;
            end
            if (mem_en_o !== e_en) bad++;
            else if (e_en && mem_adr_o !== e_adr) bad++;
            if (mem_we_o && mem_dat_o !== dd) bad++;
            if (k == drop) shr_stb_i = 1'b0;
            if (k == lat) idle_bus();
        end
        chk("ack_count", ack_n, dropit ? 0 : 1);
        if (!dropit) chk("ack_latency", ack_k, lat);
        chk("en_cycles", en_n, (int'(ic) + int'(dc)) * (int'(MW) + 1));
        chk("we_cycles", we_n, (dc && we && !wp) ? int'(MW) + 1 : 0);
        chk("adr_seq", bad, 0);
        chk("ins_dat", ins_dat_o, e_ins);
        chk("dat_dat", dat_dat_o, e_dat);
        if (dc) chk("mem_word", mem[da], ref_mem[da]);
        chk("idle_after", mem_en_o, 1'b0);
        ref_ins = e_ins;
        ref_dat = e_dat;
    endtask

    // Fetch+store interrupted by reset during the data phase.
    task automatic reset_mid(input logic [12:0] ia, input logic [14:0] da,
                             input logic [15:0] dd);
        ins_adr_i = ia; ins_cyc_i = 1'b1;
        dat_adr_i = da; dat_dat_i = dd; dat_we_i = 1'b1; dat_cyc_i = 1'b1;
        shr_stb_i = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= int'(MW) + 2; k++) @(negedge clk);
        chk("pre_rst_we", mem_we_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_en", mem_en_o, 1'b0);
        chk("rst_we", mem_we_o, 1'b0);
        chk("rst_ack", shr_ack_o, 1'b0);
        chk("rst_adr", mem_adr_o, 15'd0);
        chk("rst_ins", ins_dat_o, 16'd0);
        chk("rst_dat", dat_dat_o, 16'd0);
        idle_bus();
        @(negedge clk);
        chk("rst_nowrite", mem[da], ref_mem[da]);
        rst_n = 1'b1;
        ref_ins = 16'd0;
        ref_dat = 16'd0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [14:0] a;
        int ty;
        for (int i = 0; i < 32768; i++) ref_mem[i] = init_val(i);
        @(negedge clk);
        @(negedge clk);
        chk("reset_ack", shr_ack_o, 1'b0);
        chk("reset_en", mem_en_o, 1'b0);
        chk("reset_we", mem_we_o, 1'b0);
        chk("reset_adr", mem_adr_o, 15'd0);
        chk("reset_mdat", mem_dat_o, 16'd0);
        chk("reset_ins", ins_dat_o, 16'd0);
        chk("reset_dat", dat_dat_o, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        set_mem(15'h0005, 16'h1234);
        txn(1, 0, 0, 13'h0005, 15'h0, 16'h0, 0);
        chk("t1_ins", ins_dat_o, 16'h1234);

        set_mem(15'h0010, 16'hBEEF);
        set_mem(15'h2000, 16'hCAFE);
        txn(1, 1, 0, 13'h0010, 15'h2000, 16'h0, 0);
        chk("t2_ins", ins_dat_o, 16'hBEEF);
        chk("t2_dat", dat_dat_o, 16'hCAFE);

        txn(1, 1, 1, 13'h0010, 15'h2001, 16'h5A5A, 0);
        chk("t3_dat_hold", dat_dat_o, 16'hCAFE);
        txn(0, 1, 0, 13'h0, 15'h2001, 16'h0, 0);
        chk("t3_readback", dat_dat_o, 16'h5A5A);

        txn(1, 1, 1, 13'h0020, 15'h2002, 16'h0F0F, 1);
        chk("t4_mem", mem[15'h2002], 16'h0F0F);

        reset_mid(13'h0030, 15'h2003, 16'h7777);
        txn(1, 0, 0, 13'h0005, 15'h0, 16'h0, 0);
        chk("t5_ins", ins_dat_o, 16'h1234);

        set_mem(15'h0003, 16'h1111);
        txn(0, 1, 1, 13'h0, 15'h0003, 16'hFFFF, 0);
`ifdef J1A_INS_WP_EN
        chk("t6_mem", mem[15'h0003], 16'h1111);
`else
        chk("t6_mem", mem[15'h0003], 16'hFFFF);
`endif

        for (int n = 0; n < 200; n++) begin
            ty = int'($urandom_range(0, 2));
            a  = 15'($urandom);
            if ($urandom_range(0, 3) == 0) a[14:13] = INS_PAGE;
            txn(ty != 2, ty != 0, 1'($urandom), 13'($urandom), a,
                16'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/j1a_bus_responder.md
Name: j1a_bus_responder

Overview:
- Wishbone responder for the J1A CPU's split instruction/data buses, which share one STB and one ACK.
- Serializes the instruction fetch and the optional data access of each CPU step onto one single-port word-wide memory.
- Returns a single shared ACK only after every requested access has completed.
- Sits between the CPU and on-board RAM, and sets the CPU's cycle rate.

Parameters:
- MEM_WAIT, 1, wait cycles after address presentation before mem_dat_i is valid (legal 0..15).
- INS_PAGE, 2'b00, memory address bits [15:14] that hold instruction space.

Ports:
- sys_clk_i  in  1  system clock, rising edge.
- sys_res_n_i  in  1  asynchronous active-low reset.
- ins_adr_i  in  13  instruction word address, bits [13:1].
- ins_cyc_i  in  1  instruction cycle request.
- ins_dat_o  out  16  fetched instruction word.
- dat_adr_i  in  15  data word address, bits [15:1].
- dat_dat_i  in  16  store datum.
- dat_dat_o  out  16  load datum.
- dat_we_i  in  1  1 = store, 0 = load.
- dat_cyc_i  in  1  data cycle request.
- shr_stb_i  in  1  shared strobe.
- shr_ack_o  out  1  shared acknowledge.
- mem_adr_o  out  15  memory word address.
- mem_dat_o  out  16  memory write data.
- mem_dat_i  in  16  memory read data.
- mem_en_o  out  1  memory enable.
- mem_we_o  out  1  memory write enable.

Behaviour:
- Reset (sys_res_n_i low, asynchronous): state IDLE; shr_ack_o, mem_en_o, mem_we_o = 0; ins_dat_o, dat_dat_o, mem_adr_o, mem_dat_o = 0; wait counter = 0. Takes effect immediately, including mid-access.
- States: IDLE, INS_RD, DAT_ACC, ACK. A 4-bit wait counter runs in INS_RD and DAT_ACC.
- IDLE: on shr_stb_i & (ins_cyc_i | dat_cyc_i) at a clock edge:
  - latch ins_cyc_i and dat_cyc_i as req_i and req_d;
  - latch dat_adr_i, dat_dat_i and dat_we_i;
  - go to INS_RD if ins_cyc_i, else DAT_ACC.
  - shr_stb_i with neither cyc set is ignored.
- INS_RD:
  - mem_en_o=1, mem_we_o=0, mem_adr_o={INS_PAGE, ins_adr_i}.
  - Lasts MEM_WAIT+1 cycles; mem_dat_i is registered into ins_dat_o at the final edge.
  - Next state is DAT_ACC if req_d, else ACK.
- DAT_ACC:
  - mem_en_o=1, mem_adr_o=latched dat address, mem_we_o=latched we, mem_dat_o=latched datum.
  - Lasts MEM_WAIT+1 cycles; mem_we_o is held for the whole phase.
  - On a load, mem_dat_i is registered into dat_dat_o at the final edge.
  - Next state is ACK.
- ACK:
  - shr_ack_o=1 for exactly one cycle if shr_stb_i is still high; then IDLE.
  - mem_en_o=0 and mem_we_o=0.
- Latency from the sampling edge to the ack cycle:
  - instruction only: MEM_WAIT+2 cycles;
  - instruction plus data: 2*MEM_WAIT+3 cycles;
  - data only: MEM_WAIT+2 cycles.
- Hold rules:
  - ins_dat_o holds its value between fetches; updated only at the end of INS_RD.
  - dat_dat_o holds its value; updated only by a load.
- Back-to-back: at least one IDLE cycle follows every ACK, so the CPU's registered dat_cyc can settle before resampling.
- Strobe dropped before ACK:
  - the memory phase in progress and any queued phase still complete, so a write already issued lands;
  - ACK state then asserts no acknowledge;
  - return to IDLE.
- ins_adr_i is used combinationally in INS_RD and must stay stable while shr_stb_i is high.
- mem_adr_o is 15 bits; no wrap or overflow logic is needed.

Optional Feature:
- Macro J1A_INS_WP_EN.
- Defined: a data store whose latched address bits [15:14] equal INS_PAGE is write-protected.
  - DAT_ACC still runs its full length and ACK is still returned.
  - mem_we_o stays 0, so memory is unchanged.
  - Loads are unaffected.
- Undefined: all stores write memory.

Test Plan:
1. Fetch only: MEM_WAIT=1, mem[0x0005]=0x1234, ins_adr_i=5, ins_cyc_i=1, dat_cyc_i=0, stb=1 -> mem_adr_o=0x0005 for 2 cycles; ack exactly 3 cycles after the sampling edge; ins_dat_o=0x1234.
2. Fetch + load: mem[0x0010]=0xBEEF, mem[0x2000]=0xCAFE, ins_adr_i=0x10, dat_adr_i=0x2000, dat_we_i=0 -> INS_RD then DAT_ACC; ack 5 cycles after sampling; ins_dat_o=0xBEEF; dat_dat_o=0xCAFE.
3. Fetch + store: dat_adr_i=0x2001, dat_dat_i=0x5A5A, dat_we_i=1 -> mem_we_o high for 2 cycles; a later readback of 0x2001 returns 0x5A5A; dat_dat_o unchanged.
4. Strobe dropped mid-operation: deassert stb during INS_RD of a fetch+store to 0x2002 with datum 0x0F0F -> no shr_ack_o pulse; mem[0x2002]=0x0F0F; FSM in IDLE.
5. Reset mid-DAT_ACC: pull sys_res_n_i low between edges -> mem_en_o, mem_we_o and shr_ack_o go to 0 before the next edge; after release, a fetch completes normally.
6. J1A_INS_WP_EN defined, INS_PAGE=0: store 0xFFFF to 0x0003 -> ack returned, mem_we_o never asserted, mem[0x0003] unchanged. Macro undefined -> mem[0x0003]=0xFFFF.
